// File: rtl/systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : systolic_ctrl
// Description : Job sequencer for a 2x2 output-stationary systolic array:
//               clears the array, feeds skewed operands, drains the pipeline
//               and captures the four accumulators.
// Revision    : 1.0  initial release
// ============================================================================
module systolic_ctrl #(
    parameter int DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a_mat,
    input  logic [31:0] b_mat,
    output logic        busy,
    output logic        done,
    output logic        arr_clr,
    output logic [7:0]  arr_a1,
    output logic [7:0]  arr_a2,
    output logic [7:0]  arr_b1,
    output logic [7:0]  arr_b2,
    input  logic [15:0] arr_c11,
    input  logic [15:0] arr_c12,
    input  logic [15:0] arr_c21,
    input  logic [15:0] arr_c22,
    output logic [15:0] res_c11,
    output logic [15:0] res_c12,
    output logic [15:0] res_c21,
    output logic [15:0] res_c22
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CLEAR = 3'd1;
    localparam logic [2:0] c_FEED  = 3'd2;
    localparam logic [2:0] c_DRAIN = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam logic [3:0] c_DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    logic [2:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;

    // r_cnt in FEED names the beat currently presented on arr_a*/arr_b*;
    // the next beat is registered one edge ahead so the outputs stay flopped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            arr_clr <= 1'b0;
            arr_a1  <= '0;
            arr_a2  <= '0;
            arr_b1  <= '0;
            arr_b2  <= '0;
            res_c11 <= '0;
            res_c12 <= '0;
            res_c21 <= '0;
            res_c22 <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a     <= a_mat;
                        r_b     <= b_mat;
                        r_state <= c_CLEAR;
                        busy    <= 1'b1;
                        arr_clr <= 1'b1;
                        arr_a1  <= '0;
                        arr_a2  <= '0;
                        arr_b1  <= '0;
                        arr_b2  <= '0;
                    end
                end
                c_CLEAR: begin
                    arr_clr <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= c_FEED;
                    arr_a1  <= r_a[7:0];
                    arr_a2  <= '0;
                    arr_b1  <= r_b[7:0];
                    arr_b2  <= '0;
                end
                c_FEED: begin
                    if (r_cnt == 4'd0) begin
                        r_cnt  <= 4'd1;
                        arr_a1 <= r_a[15:8];
                        arr_a2 <= r_a[23:16];
                        arr_b1 <= r_b[23:16];
                        arr_b2 <= r_b[15:8];
                    end else if (r_cnt == 4'd1) begin
                        r_cnt  <= 4'd2;
                        arr_a1 <= '0;
                        arr_a2 <= r_a[31:24];
                        arr_b1 <= '0;
                        arr_b2 <= r_b[31:24];
                    end else begin
                        r_cnt   <= c_DRAIN_LAST;
                        r_state <= c_DRAIN;
                        arr_a1  <= '0;
                        arr_a2  <= '0;
                        arr_b1  <= '0;
                        arr_b2  <= '0;
                    end
                end
                c_DRAIN: begin
                    if (r_cnt == 4'd0) begin
                        res_c11 <= arr_c11;
                        res_c12 <= arr_c12;
                        res_c21 <= arr_c21;
                        res_c22 <= arr_c22;
                        done    <= 1'b1;
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_DONE: begin
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                    arr_clr <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_ctrl
// Description : Self-checking bench for systolic_ctrl with a behavioural
//               2x2 systolic array attached and a matrix-product reference.
// Revision    : 1.0  initial release
// ============================================================================
module tb_systolic_ctrl;

    localparam int c_D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a_mat;
    logic [31:0] b_mat;
    logic        busy;
    logic        done;
    logic        arr_clr;
    logic [7:0]  arr_a1, arr_a2, arr_b1, arr_b2;
    logic [15:0] arr_c11, arr_c12, arr_c21, arr_c22;
    logic [15:0] res_c11, res_c12, res_c21, res_c22;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    systolic_ctrl #(.DRAIN_CYCLES(c_D)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a_mat(a_mat), .b_mat(b_mat),
        .busy(busy), .done(done), .arr_clr(arr_clr),
        .arr_a1(arr_a1), .arr_a2(arr_a2), .arr_b1(arr_b1), .arr_b2(arr_b2),
        .arr_c11(arr_c11), .arr_c12(arr_c12), .arr_c21(arr_c21), .arr_c22(arr_c22),
        .res_c11(res_c11), .res_c12(res_c12), .res_c21(res_c21), .res_c22(res_c22)
    );

    // Output-stationary 2x2 array: a flows right, b flows down, one flop per hop.
    logic [7:0] r_pa11, r_pb11, r_pa21, r_pb12;
    always @(posedge clk) begin
        if (arr_clr) begin
            arr_c11 <= '0; arr_c12 <= '0; arr_c21 <= '0; arr_c22 <= '0;
            r_pa11  <= '0; r_pb11  <= '0; r_pa21  <= '0; r_pb12  <= '0;
        end else begin
            arr_c11 <= arr_c11 + 16'(arr_a1 * arr_b1);
            arr_c12 <= arr_c12 + 16'(r_pa11 * arr_b2);
            arr_c21 <= arr_c21 + 16'(arr_a2 * r_pb11);
            arr_c22 <= arr_c22 + 16'(r_pa21 * r_pb12);
            r_pa11  <= arr_a1;
            r_pb11  <= arr_b1;
            r_pa21  <= arr_a2;
            r_pb12  <= arr_b2;
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    function automatic logic [63:0] matmul(input logic [31:0] a, input logic [31:0] b);
        int x [2][2];
        int y [2][2];
        int c [2][2];
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                x[i][j] = int'(a[8*(2*i+j) +: 8]);
                y[i][j] = int'(b[8*(2*i+j) +: 8]);
            end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                c[i][j] = (x[i][0] * y[0][j] + x[i][1] * y[1][j]) % 65536;
        return {16'(c[1][1]), 16'(c[1][0]), 16'(c[0][1]), 16'(c[0][0])};
    endfunction

    // Expected {arr_clr, a1, a2, b1, b2} in cycle k after the accept edge.
    function automatic logic [32:0] exp_sched(input int k, input logic [31:0] a,
                                              input logic [31:0] b);
        case (k)
            1: return {1'b1, 32'h0};
            2: return {1'b0, a[7:0],   8'h00,      b[7:0],    8'h00};
            3: return {1'b0, a[15:8],  a[23:16],   b[23:16],  b[15:8]};
            4: return {1'b0, 8'h00,    a[31:24],   8'h00,     b[31:24]};
            default: return 33'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] res_now();
        return {res_c22, res_c21, res_c12, res_c11};
    endfunction

    // Entered in an IDLE cycle; returns in the IDLE cycle after DONE.
    task automatic run_job(input logic [31:0] a, input logic [31:0] b,
                           input bit hold, input bit scramble,
                           output logic [63:0] res_out);
        logic [63:0] prev;
        int k;
        prev  = res_now();
        a_mat = a;
        b_mat = b;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        k = 1;
        while (!done && k < 40) begin
            if (scramble) begin
                a_mat = $urandom;
                b_mat = $urandom;
            end
            check("busy_in_job", 64'(busy), 64'd1);
            check("sched", 64'({arr_clr, arr_a1, arr_a2, arr_b1, arr_b2}),
                  64'(exp_sched(k, a, b)));
            check("res_hold_in_job", res_now(), prev);
            tick();
            k++;
        end
        check("latency", 64'(k), 64'(5 + c_D));
        check("busy_at_done", 64'(busy), 64'd1);
        res_out = res_now();
        tick();
        check("idle_after_done", 64'({busy, done}), 64'd0);
    endtask

    vec_t        vecs [6];
    logic [63:0] got;
    logic [63:0] held;
    logic [31:0] ra, rb;

    initial begin
        vecs[0] = '{32'h04030201, 32'h08070605, {16'd50, 16'd43, 16'd22, 16'd19}};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, {16'd64514, 16'd64514, 16'd64514, 16'd64514}};
        vecs[2] = '{32'h01000001, 32'h06070809, {16'd6, 16'd7, 16'd8, 16'd9}};
        vecs[3] = '{32'h00000000, 32'h00000000, 64'h0};
        vecs[4] = '{32'h03000002, 32'h281E140A, {16'd120, 16'd90, 16'd40, 16'd20}};
        vecs[5] = '{32'h00000100, 32'h00010000, {16'd0, 16'd0, 16'd0, 16'd1}};

        rst   = 1'b1;
        start = 1'b0;
        a_mat = '0;
        b_mat = '0;
        repeat (3) tick();
        check("reset_ctrl", 64'({busy, done, arr_clr, arr_a1, arr_a2, arr_b1, arr_b2}), 64'd0);
        check("reset_res", res_now(), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].a, vecs[i].b, 1'b0, 1'b0, got);
            check($sformatf("vec%0d_res", i), got, vecs[i].exp);
        end

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_job(ra, rb, 1'b0, i[0], got);
            check($sformatf("rand%0d_res", i), got, matmul(ra, rb));
        end

        // start held high across two jobs with operands changing mid-job
        ra = $urandom;
        rb = $urandom;
        run_job(ra, rb, 1'b1, 1'b1, got);
        check("hold_job1_res", got, matmul(ra, rb));
        ra = $urandom;
        rb = $urandom;
        run_job(ra, rb, 1'b1, 1'b1, got);
        check("hold_job2_res", got, matmul(ra, rb));
        start = 1'b0;
        tick();
        check("hold_no_extra_job", 64'(busy), 64'd0);

        held = res_now();
        for (int i = 0; i < 20; i++) begin
            a_mat = $urandom;
            b_mat = $urandom;
            tick();
            check("idle_res_held", res_now(), held);
            check("idle_done_low", 64'({busy, done}), 64'd0);
        end

        // start coincident with reset must not launch a job
        rst   = 1'b1;
        start = 1'b1;
        tick();
        check("start_with_rst", 64'(busy), 64'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("after_rst_idle", 64'(busy), 64'd0);

        run_job(32'h04030201, 32'h08070605, 1'b0, 1'b0, got);
        check("pre_abort_res", got, 64'({16'd50, 16'd43, 16'd22, 16'd19}));

        // abort during FEED beat1
        a_mat = 32'h11223344;
        b_mat = 32'h55667788;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("beat1_reached", 64'(arr_a2), 64'h22);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ctrl", 64'({busy, done, arr_clr, arr_a1, arr_a2, arr_b1, arr_b2}), 64'd0);
        check("abort_res", res_now(), 64'd0);
        run_job(32'h01000001, 32'h06070809, 1'b0, 1'b0, got);
        check("post_abort_res", got, 64'({16'd6, 16'd7, 16'd8, 16'd9}));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter: DRAIN_CYCLES, default 4, number of all-zero cycles driven after the last operand beat before results are captured; legal range 3..15.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-004 Port: start  in  1  job request; sampled only in IDLE.
REQ-005 Port: a_mat  in  32  matrix A; a11=[7:0], a12=[15:8], a21=[23:16], a22=[31:24], unsigned.
REQ-006 Port: b_mat  in  32  matrix B; b11=[7:0], b12=[15:8], b21=[23:16], b22=[31:24], unsigned.
REQ-007 Port: busy  out  1  high in every non-IDLE state.
REQ-008 Port: done  out  1  one-cycle pulse; res_* valid in that cycle.
REQ-009 Port: arr_clr  out  1  accumulator clear to the 2x2 array (drives array rst).
REQ-010 Port: arr_a1, arr_a2, arr_b1, arr_b2  out  8 each  skewed operand streams to array row/column edges.
REQ-011 Port: arr_c11, arr_c12, arr_c21, arr_c22  in  16 each  array accumulator outputs.
REQ-012 Port: res_c11, res_c12, res_c21, res_c22  out  16 each  captured results, held until next capture.

Function
REQ-013 States SHALL be IDLE, CLEAR, FEED, DRAIN, DONE; all outputs registered.
REQ-014 IDLE: start=1 at edge N latches a_mat/b_mat into internal operand regs and enters CLEAR for cycle N+1; start=0 stays IDLE.
REQ-015 CLEAR (1 cycle): arr_clr=1, arr_a*/arr_b*=0; next FEED.
REQ-016 FEED SHALL last exactly 3 cycles (beat counter 0..2), arr_clr=0, drive from latched operands:
- beat0: a1=a11, a2=0, b1=b11, b2=0
- beat1: a1=a12, a2=a21, b1=b21, b2=b12
- beat2: a1=0, a2=a22, b1=0, b2=b22
REQ-017 DRAIN SHALL last exactly DRAIN_CYCLES cycles with all arr_a*/arr_b*=0; counter counts down from DRAIN_CYCLES-1 to 0.
REQ-018 On the last DRAIN edge res_c* SHALL capture arr_c* verbatim (no truncation or extension by this block); next DONE.
REQ-019 DONE (1 cycle): done=1, busy=1; next IDLE unconditionally; start in DONE ignored.
REQ-020 Latency: start accepted at edge N -> done high in cycle N+5+DRAIN_CYCLES; back-to-back start in the cycle after DONE SHALL be accepted.
REQ-021 start while busy=1 SHALL be ignored; a_mat/b_mat changes after acceptance SHALL not affect the running job.
REQ-022 busy=0 and done=0 in IDLE; res_c* SHALL change only on capture edges.
REQ-023 Arithmetic overflow (sum >= 65536) is the array's modulo-2^16 behaviour and SHALL be passed through unchanged.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, counters 0, busy=0, done=0, arr_clr=0, arr_a*/arr_b*=0, res_c*=0, operand regs 0, from any state including mid-FEED/DRAIN.
REQ-025 start asserted together with rst SHALL be ignored; first accepted start is at least one edge after rst falls.

Verification
REQ-026 A=[1 2;3 4], B=[5 6;7 8], start one cycle, DRAIN_CYCLES=4, real array attached -> done exactly 9 cycles after accept edge; res = 19,22,43,50.
REQ-027 Operand schedule check: same job -> arr_a1 sequence 1,2,0; arr_a2 0,3,4; arr_b1 5,7,0; arr_b2 0,6,8 on the three FEED cycles; arr_clr high only in the cycle before beat0.
REQ-028 start held high through a job with new a_mat/b_mat mid-job -> exactly one job per IDLE visit, result from operands latched at acceptance; second job starts the cycle after DONE.
REQ-029 rst pulsed during FEED beat1 -> next cycle busy=0, all arr_* and res_* 0; following job A=I, B=[9 8;7 6] -> res 9,8,7,6.
REQ-030 All operands 255 -> res each 64514 (130050 mod 65536).
REQ-031 Job 1 result held: after job 1 done, idle 20 cycles -> res_c* unchanged, done stays 0.
